// File: rtl/bus_burst_slave.sv
// rtl/bus_burst_slave.sv - word-addressed SRAM target for the shared burst bus
//
// Purpose: decodes a fixed address window and serves single/burst writes with
// byte enables and single/burst reads after a programmable number of wait
// states. Outputs are registered alongside the state.
//
// Ports:
//   clock                 in   rising-edge clock
//   reset                 in   synchronous, active-high
//   begin_transaction_in  in   request strobe, address/attributes valid same cycle
//   address_data_in       in   [31:0] byte address in begin cycle, write data after
//   read_n_write_in       in   1 = read
//   byte_enables_in       in   [3:0] per-byte write enables for the whole burst
//   burst_size_in         in   [7:0] words minus one
//   data_valid_in         in   write word present
//   end_transaction_in    in   initiator closes a write
//   address_data_out      out  [31:0] read data, 0 when not driving
//   data_valid_out        out  read word valid
//   end_transaction_out   out  one-cycle close of a read or error response
//   busy_out              out  write stall
//   error_out             out  one-cycle error flag
module bus_burst_slave #(
    parameter logic [31:0] baseAddress    = 32'h5000_0000,
    parameter int          addressBits    = 10,
    parameter int          readWaitStates = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        begin_transaction_in,
    input  logic [31:0] address_data_in,
    input  logic        read_n_write_in,
    input  logic [3:0]  byte_enables_in,
    input  logic [7:0]  burst_size_in,
    input  logic        data_valid_in,
    input  logic        end_transaction_in,
    output logic [31:0] address_data_out,
    output logic        data_valid_out,
    output logic        end_transaction_out,
    output logic        busy_out,
    output logic        error_out
);

    localparam int                     WORDS     = 1 << addressBits;
    localparam logic [addressBits-1:0] PTR_ONE   = 1;
    localparam logic [3:0]             WAIT_LAST = 4'(readWaitStates - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WSETUP,
        S_WRITE,
        S_WDRAIN,
        S_RWAIT,
        S_READ,
        S_REND,
        S_ERR
    } state_t;

    state_t                 state_q;
    logic [addressBits-1:0] ptr_q;
    logic [7:0]             burst_q;
    logic [7:0]             cnt_q;
    logic [3:0]             wait_q;
    logic [3:0]             be_q;
    logic                   rd_q;
    logic [31:0]            dout_q;
    logic                   dv_q;
    logic                   eot_q;
    logic                   busy_q;
    logic                   err_q;

    logic [31:0] mem [WORDS];

    logic                   hit;
    logic [addressBits-1:0] req_ptr;
    logic [addressBits-1:0] ptr_d;
    logic                   wr_en;

    assign hit     = begin_transaction_in &&
                     (address_data_in[31:addressBits+2] == baseAddress[31:addressBits+2]);
    assign req_ptr = address_data_in[addressBits+1:2];
    // Pointer wraps naturally at the top of the window.
    assign ptr_d   = ptr_q + PTR_ONE;
    assign wr_en   = !reset && (state_q == S_WRITE) && data_valid_in;

    // Memory has no reset: contents survive a bus reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[ptr_q][8*b +: 8] <= address_data_in[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            burst_q <= '0;
            cnt_q   <= '0;
            wait_q  <= '0;
            be_q    <= '0;
            rd_q    <= 1'b0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            eot_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // All response outputs are single-cycle unless re-asserted below.
            dout_q <= '0;
            dv_q   <= 1'b0;
            eot_q  <= 1'b0;
            busy_q <= 1'b0;
            err_q  <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (hit) begin
                        rd_q    <= read_n_write_in;
                        be_q    <= byte_enables_in;
                        burst_q <= burst_size_in;
                        cnt_q   <= '0;
                        wait_q  <= '0;
                        ptr_q   <= req_ptr;
                        if (address_data_in[1:0] != 2'b00) begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                            eot_q   <= read_n_write_in;
                        end else if (!read_n_write_in) begin
                            state_q <= S_WSETUP;
                            busy_q  <= 1'b1;
                        end else if (readWaitStates == 0) begin
                            // Fetch the first word now so it is on the bus next cycle.
                            state_q <= S_READ;
                            dv_q    <= 1'b1;
                            dout_q  <= mem[req_ptr];
                            ptr_q   <= req_ptr + PTR_ONE;
                        end else begin
                            state_q <= S_RWAIT;
                        end
                    end
                end

                S_WSETUP: state_q <= S_WRITE;

                S_WRITE: begin
                    if (data_valid_in) begin
                        ptr_q <= ptr_d;
                        cnt_q <= cnt_q + 8'd1;
                        if (cnt_q == burst_q) begin
                            state_q <= S_WDRAIN;
                        end
                    end
                    // An early close wins over the move to WDRAIN.
                    if (end_transaction_in) begin
                        state_q <= S_IDLE;
                    end
                end

                S_WDRAIN: begin
                    if (end_transaction_in) begin
                        state_q <= S_IDLE;
                    end
                end

                S_RWAIT: begin
                    if (wait_q == WAIT_LAST) begin
                        state_q <= S_READ;
                        dv_q    <= 1'b1;
                        dout_q  <= mem[ptr_q];
                        ptr_q   <= ptr_d;
                    end else begin
                        wait_q <= wait_q + 4'd1;
                    end
                end

                // cnt_q is the index of the word currently on the bus.
                S_READ: begin
                    if (cnt_q == burst_q) begin
                        state_q <= S_REND;
                        eot_q   <= 1'b1;
                    end else begin
                        dv_q   <= 1'b1;
                        dout_q <= mem[ptr_q];
                        ptr_q  <= ptr_d;
                        cnt_q  <= cnt_q + 8'd1;
                    end
                end

                S_REND: state_q <= S_IDLE;

                S_ERR: state_q <= rd_q ? S_IDLE : S_WDRAIN;

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign address_data_out    = dout_q;
    assign data_valid_out      = dv_q;
    assign end_transaction_out = eot_q;
    assign busy_out            = busy_q;
    assign error_out           = err_q;

endmodule

// File: tb/tb_bus_burst_slave.sv
// tb/tb_bus_burst_slave.sv - self-checking bench for bus_burst_slave
module tb_bus_burst_slave;

    localparam logic [31:0] BASE = 32'h5000_0000;
    localparam int          AB   = 10;
    localparam int          W    = 1;
    localparam int          NW   = 1 << AB;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        begin_transaction_in;
    logic [31:0] address_data_in;
    logic        read_n_write_in;
    logic [3:0]  byte_enables_in;
    logic [7:0]  burst_size_in;
    logic        data_valid_in;
    logic        end_transaction_in;
    logic [31:0] address_data_out;
    logic        data_valid_out;
    logic        end_transaction_out;
    logic        busy_out;
    logic        error_out;

    always #5 clock = ~clock;

    bus_burst_slave #(
        .baseAddress    (BASE),
        .addressBits    (AB),
        .readWaitStates (W)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .begin_transaction_in (begin_transaction_in),
        .address_data_in      (address_data_in),
        .read_n_write_in      (read_n_write_in),
        .byte_enables_in      (byte_enables_in),
        .burst_size_in        (burst_size_in),
        .data_valid_in        (data_valid_in),
        .end_transaction_in   (end_transaction_in),
        .address_data_out     (address_data_out),
        .data_valid_out       (data_valid_out),
        .end_transaction_out  (end_transaction_out),
        .busy_out             (busy_out),
        .error_out            (error_out)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] ref_mem [NW];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic idle_inputs();
        begin_transaction_in = 1'b0;
        address_data_in      = '0;
        read_n_write_in      = 1'b0;
        byte_enables_in      = '0;
        burst_size_in        = '0;
        data_valid_in        = 1'b0;
        end_transaction_in   = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".data"}, address_data_out, 32'h0);
        check({tag, ".flags"}, 32'({data_valid_out, end_transaction_out, busy_out, error_out}), 32'h0);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic do_write(input logic [31:0] addr, input logic [3:0] be, input int burst,
                            input int nwords, input bit end_with_last,
                            input bit use_fixed, input logic [31:0] fixed);
        int ptr;
        int acc;
        ptr = int'(addr[AB+1:2]);
        acc = 0;
        begin_transaction_in = 1'b1;
        address_data_in      = addr;
        read_n_write_in      = 1'b0;
        byte_enables_in      = be;
        burst_size_in        = 8'(burst);
        @(negedge clock);
        check("wr.busy", 32'(busy_out), 32'h1);
        check("wr.err", 32'(error_out), 32'h0);
        begin_transaction_in = 1'b0;
        data_valid_in        = 1'b1;
        address_data_in      = $urandom;     // offered during setup, must be dropped
        for (int i = 0; i < nwords; i++) begin
            while ($urandom_range(0, 3) == 0) begin
                @(negedge clock);
                check("wr.nobusy", 32'(busy_out), 32'h0);
                data_valid_in   = 1'b0;
                address_data_in = $urandom;
            end
            @(negedge clock);
            data_valid_in      = 1'b1;
            address_data_in    = use_fixed ? fixed : $urandom;
            end_transaction_in = end_with_last && (i == nwords - 1);
            if (acc <= burst) begin
                ref_mem[(ptr + acc) % NW] = merge(ref_mem[(ptr + acc) % NW], address_data_in, be);
                acc++;
            end
        end
        if (!end_with_last) begin
            @(negedge clock);
            data_valid_in      = 1'b0;
            end_transaction_in = 1'b1;
        end
        @(negedge clock);
        idle_inputs();
    endtask

    task automatic do_read(input logic [31:0] addr, input int burst, input int reset_k);
        int ptr;
        int last;
        bit dv_exp;
        ptr  = int'(addr[AB+1:2]);
        last = 2 + W + burst;
        begin_transaction_in = 1'b1;
        address_data_in      = addr;
        read_n_write_in      = 1'b1;
        byte_enables_in      = 4'($urandom);
        burst_size_in        = 8'(burst);
        for (int k = 1; k <= last; k++) begin
            @(negedge clock);
            dv_exp = (k >= 1 + W) && (k <= 1 + W + burst);
            check("rd.dv", 32'(data_valid_out), 32'(dv_exp));
            check("rd.data", address_data_out, dv_exp ? ref_mem[(ptr + k - 1 - W) % NW] : 32'h0);
            check("rd.eot", 32'(end_transaction_out), 32'(k == last));
            check("rd.busyerr", 32'({busy_out, error_out}), 32'h0);
            // Stray begins while busy must be ignored.
            begin_transaction_in = (k < last) ? 1'($urandom_range(0, 1)) : 1'b0;
            address_data_in      = BASE | ($urandom & 32'h0000_0FFF);
            read_n_write_in      = 1'($urandom);
            burst_size_in        = 8'($urandom);
            if (k == reset_k) begin
                reset                = 1'b1;
                begin_transaction_in = 1'b0;
                @(negedge clock);
                check_quiet("rd.reset");
                reset = 1'b0;
                idle_inputs();
                return;
            end
        end
        @(negedge clock);
        check_quiet("rd.after");
        idle_inputs();
    endtask

    task automatic do_err(input logic [31:0] addr, input bit rnw);
        begin_transaction_in = 1'b1;
        address_data_in      = addr;
        read_n_write_in      = rnw;
        byte_enables_in      = 4'hF;
        burst_size_in        = 8'd3;
        @(negedge clock);
        check("err.err", 32'(error_out), 32'h1);
        check("err.eot", 32'(end_transaction_out), 32'(rnw));
        check("err.dv", 32'({data_valid_out, busy_out}), 32'h0);
        check("err.data", address_data_out, 32'h0);
        begin_transaction_in = 1'b0;
        if (!rnw) begin
            for (int i = 0; i < 3; i++) begin
                data_valid_in   = 1'b1;
                address_data_in = $urandom;
                @(negedge clock);
                check_quiet("err.drain");
            end
            data_valid_in      = 1'b0;
            end_transaction_in = 1'b1;
        end
        @(negedge clock);
        check_quiet("err.after");
        idle_inputs();
    endtask

    task automatic do_miss(input logic [31:0] addr, input bit rnw);
        begin_transaction_in = 1'b1;
        address_data_in      = addr;
        read_n_write_in      = rnw;
        byte_enables_in      = 4'hF;
        burst_size_in        = 8'd2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check_quiet("miss");
            begin_transaction_in = 1'b0;
            data_valid_in        = !rnw;
            address_data_in      = $urandom;
            end_transaction_in   = !rnw && (i == 3);
        end
        @(negedge clock);
        idle_inputs();
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int op;
        int bst;
        logic [31:0] a;
        idle_inputs();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check_quiet("reset");
        reset = 1'b0;

        // Fill the whole window so every later read has a known expectation.
        for (int f = 0; f < 4; f++)
            do_write(BASE + 32'(f * 1024), 4'hF, 255, 256, f[0], 1'b0, 32'h0);

        do_write(32'h5000_0010, 4'hF, 0, 1, 1'b1, 1'b1, 32'hDEAD_BEEF);
        do_read(32'h5000_0010, 0, -1);

        do_write(32'h5000_0020, 4'hF, 0, 1, 1'b0, 1'b1, 32'hFFFF_FFFF);
        do_write(32'h5000_0020, 4'b0101, 0, 1, 1'b1, 1'b1, 32'h1122_3344);
        check("pbe.model", ref_mem[8], 32'hFF22_FF44);
        do_read(32'h5000_0020, 0, -1);

        do_write(32'h5000_0FF0, 4'hF, 15, 16, 1'b0, 1'b0, 32'h0);
        do_read(32'h5000_0FF0, 15, -1);

        do_write(32'h5000_0100, 4'hF, 7, 3, 1'b0, 1'b0, 32'h0);
        do_write(32'h5000_0140, 4'b1010, 7, 3, 1'b1, 1'b0, 32'h0);
        do_read(32'h5000_0100, 31, -1);

        do_write(32'h5000_0200, 4'hF, 1, 4, 1'b1, 1'b0, 32'h0);
        do_read(32'h5000_01FC, 3, -1);

        do_err(32'h5000_0002, 1'b1);
        do_err(32'h5000_0001, 1'b0);
        do_miss(32'h4000_0000, 1'b1);
        do_miss(32'h4000_0000, 1'b0);
        do_read(32'h5000_0000, 3, -1);

        do_read(32'h5000_0300, 7, 2 + W + 3 - 1);
        do_read(32'h5000_0300, 7, -1);

        for (int it = 0; it < 40; it++) begin
            op  = $urandom_range(0, 9);
            bst = $urandom_range(0, 20);
            a   = BASE + (32'($urandom_range(0, NW - 1)) << 2);
            if (op < 4)
                do_write(a, 4'($urandom), bst, $urandom_range(1, bst + 3), 1'($urandom), 1'b0, 32'h0);
            else if (op < 8)
                do_read(a, bst, -1);
            else if (op == 8)
                do_err(a | 32'($urandom_range(1, 3)), 1'($urandom));
            else
                do_miss(32'h5000_1000 + (32'($urandom_range(0, 255)) << 2), 1'($urandom));
        end
        do_read(BASE, 255, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
